// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
// Op codes 5-7 are reserved and decode exactly like PC_SEQ.
package pc_pkg;

  localparam int unsigned PC_OP_W = 3;

  typedef enum logic [PC_OP_W-1:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_op_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack with a top pointer and a saturating count.
// A push when full overwrites the oldest entry; a pop when empty is ignored.
module ret_addr_stack #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d, wr_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty;

  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign wr_ptr = top_q + PTR_W'(1);
  assign top    = mem_q[top_q];
  assign count  = cnt_q;
  assign ovf    = push && full;
  assign unf    = pop && !push && empty;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      top_d = wr_ptr;
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q <= '1;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; a zero count already marks it invalid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter: next-PC mux, pc register, return-address stack and
// registered overflow/underflow pulses.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned INC       = 1,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [2:0]                  op,
  input  logic [PC_W-1:0]             offset,
  input  logic [PC_W-1:0]             target,
  output logic [PC_W-1:0]             pc,
  output logic [PC_W-1:0]             pc_next,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_full,
  output logic                        ras_empty,
  output logic                        ras_ovf,
  output logic                        ras_unf
);

  localparam int unsigned      CNT_W = $clog2(RAS_DEPTH) + 1;
  localparam logic [PC_W-1:0]  INC_V = PC_W'(INC);
  localparam logic [PC_W-1:0]  RST_V = PC_W'(RESET_VEC);

  logic [PC_W-1:0]  pc_q, pc_d, seq_pc, ras_top;
  logic [CNT_W-1:0] cnt;
  logic             ras_push, ras_pop, ovf_raw, unf_raw;
  logic             ovf_q, unf_q;

  assign seq_pc   = pc_q + INC_V;
  assign ras_push = !stall && (op == PC_CALL);
  assign ras_pop  = !stall && (op == PC_RET);

  ret_addr_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (seq_pc),
    .top   (ras_top),
    .count (cnt),
    .ovf   (ovf_raw),
    .unf   (unf_raw)
  );

  always_comb begin
    pc_d = seq_pc;
    if (stall) begin
      pc_d = pc_q;
    end else begin
      case (op)
        PC_BRANCH: pc_d = pc_q + offset;
        PC_JUMP,
        PC_CALL:   pc_d = target;
        PC_RET:    pc_d = ras_empty ? seq_pc : ras_top;
        default:   pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RST_V;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_raw;
      unf_q <= unf_raw;
    end
  end

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign ras_count = cnt;
  assign ras_full  = (cnt == CNT_W'(RAS_DEPTH));
  assign ras_empty = (cnt == '0);
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with RESET_VEC = 0x0100 and a 4-entry stack.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  op;
  logic [15:0] offset;
  logic [15:0] target;
  logic [15:0] pc, pc_next;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [2:0] OP_SEQ = 3'd0, OP_BR = 3'd1, OP_JMP = 3'd2,
                         OP_CALL = 3'd3, OP_RET = 3'd4;

  pc_unit #(
    .PC_W      (16),
    .INC       (1),
    .RESET_VEC (16'h0100),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .op        (op),
    .offset    (offset),
    .target    (target),
    .pc        (pc),
    .pc_next   (pc_next),
    .ras_count (ras_count),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 clk = ~clk;

  // Drive one op at a negedge, let one rising edge pass, return at the next negedge.
  task automatic step(input logic [2:0] o, input logic [15:0] off, input logic [15:0] tgt);
    op = o; offset = off; target = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compares the registered state against expected values.
  task automatic expect_state(input string name, input logic [15:0] e_pc, input logic [2:0] e_cnt,
                              input logic e_full, input logic e_empty, input logic e_ovf, input logic e_unf);
    total_cnt++;
    if ({pc, ras_count, ras_full, ras_empty, ras_ovf, ras_unf} !==
        {e_pc, e_cnt, e_full, e_empty, e_ovf, e_unf})
      $display("FAIL %s: pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b, expected pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b",
               name, pc, ras_count, ras_full, ras_empty, ras_ovf, ras_unf,
               e_pc, e_cnt, e_full, e_empty, e_ovf, e_unf);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; op = OP_SEQ; offset = '0; target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_state("reset_state", 16'h0100, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (pc_next !== 16'h0101) $display("FAIL reset_pc_next: got %h expected %h", pc_next, 16'h0101);
    else pass_cnt++;
  endtask

  task automatic test_seq;
    step(OP_SEQ, '0, '0);
    expect_state("seq_1", 16'h0101, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_SEQ, '0, '0);
    expect_state("seq_2", 16'h0102, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5, '0, '0);   // reserved op behaves as sequential
    expect_state("seq_reserved", 16'h0103, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_branch_wrap;
    step(OP_JMP, '0, 16'h0010);
    expect_state("jump_0010", 16'h0010, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    op = OP_BR; offset = 16'hFFF0; #1;
    total_cnt++;
    if (pc_next !== 16'h0000) $display("FAIL branch_neg_pc_next: got %h expected %h", pc_next, 16'h0000);
    else pass_cnt++;
    step(OP_BR, 16'hFFF0, '0);
    expect_state("branch_neg", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_BR, 16'h0025, '0);
    expect_state("branch_pos", 16'h0025, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_JMP, '0, 16'hFFFF);
    step(OP_SEQ, '0, '0);
    expect_state("seq_wrap", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_call_ret;
    step(OP_JMP, '0, 16'h0050);
    step(OP_CALL, '0, 16'h0200);
    expect_state("call_1", 16'h0200, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_CALL, '0, 16'h0300);
    expect_state("call_2", 16'h0300, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_RET, '0, '0);
    expect_state("ret_1", 16'h0201, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_RET, '0, '0);
    expect_state("ret_2", 16'h0051, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    step(OP_CALL, '0, 16'h0400);
    expect_state("b2b_call", 16'h0400, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op = OP_RET; #1;
    total_cnt++;
    if (pc_next !== 16'h0052) $display("FAIL b2b_ret_pc_next: got %h expected %h", pc_next, 16'h0052);
    else pass_cnt++;
    step(OP_RET, '0, '0);
    expect_state("b2b_ret", 16'h0052, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    step(OP_JMP, '0, 16'h1000);
    step(OP_CALL, '0, 16'h2000);   // pushes 1001
    step(OP_CALL, '0, 16'h3000);   // pushes 2001
    step(OP_CALL, '0, 16'h4000);   // pushes 3001
    step(OP_CALL, '0, 16'h5000);   // pushes 4001
    expect_state("fill_4", 16'h5000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_CALL, '0, 16'h6000);   // pushes 5001 over 1001
    expect_state("ovf_call", 16'h6000, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    step(OP_RET, '0, '0);
    expect_state("ovf_ret_1", 16'h5001, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_RET, '0, '0);
    expect_state("ovf_ret_2", 16'h4001, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_RET, '0, '0);
    expect_state("ovf_ret_3", 16'h3001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_RET, '0, '0);
    expect_state("ovf_ret_4", 16'h2001, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_RET, '0, '0);
    expect_state("unf_ret", 16'h2002, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(OP_SEQ, '0, '0);
    expect_state("unf_clear", 16'h2003, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    step(OP_CALL, '0, 16'h0800);   // pushes 2004
    expect_state("pre_stall_call", 16'h0800, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    op = OP_CALL; target = 16'h7777; #1;
    total_cnt++;
    if (pc_next !== 16'h0800) $display("FAIL stall_pc_next: got %h expected %h", pc_next, 16'h0800);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step(OP_CALL, '0, 16'h7777);
    expect_state("stall_call_hold", 16'h0800, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_RET, '0, '0);
    expect_state("stall_ret_hold", 16'h0800, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    step(OP_RET, '0, '0);
    expect_state("post_stall_ret", 16'h2004, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_async;
    step(OP_CALL, '0, 16'h0900);
    expect_state("pre_reset_call", 16'h0900, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op = OP_SEQ;
    #2 reset = 1'b1;
    #1;
    expect_state("async_reset", 16'h0100, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(OP_SEQ, '0, '0);
    expect_state("after_reset_seq", 16'h0101, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_RET, '0, '0);
    expect_state("after_reset_ret", 16'h0102, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch_wrap();
    test_call_ret();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_reset_async();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
